// File: rtl/booth_r4_mult.sv
// Radix-4 (modified Booth) sequential multiplier: two multiplier bits retired per cycle,
// signed/unsigned per operation, start/busy/done handshake with a held product register.
module booth_r4_mult #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH/2+2)
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int N = WIDTH + 2;
  localparam int K = WIDTH/2 + 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t             state_reg, state_next;
  logic [N:0]         m_reg;
  logic [N:0]         acc_reg;
  logic [N-1:0]       q_reg;
  logic               qm1_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic [2*WIDTH-1:0] product_reg;

  logic               load, step, finish;
  logic [N:0]         ext_a;
  logic [N-1:0]       ext_b;
  logic [N:0]         m2;
  logic [N:0]         addend;
  logic [N:0]         sum;
  logic [N:0]         acc_next;
  logic [N-1:0]       q_next;

  // Extra headroom bits keep unsigned operands positive in Booth terms and let 2M fit.
  assign ext_a = signed_mode ? {{3{a[WIDTH-1]}}, a} : {3'b000, a};
  assign ext_b = signed_mode ? {{2{b[WIDTH-1]}}, b} : {2'b00, b};
  assign m2    = {m_reg[N-1:0], 1'b0};

  always_comb begin
    addend = '0;
    case ({q_reg[1:0], qm1_reg})
      3'b001, 3'b010: addend = m_reg;
      3'b011:         addend = m2;
      3'b100:         addend = -m2;
      3'b101, 3'b110: addend = -m_reg;
      default:        addend = '0;
    endcase
  end

  assign sum      = acc_reg + addend;
  assign acc_next = {{2{sum[N]}}, sum[N:2]};
  assign q_next   = {sum[1:0], q_reg[N-1:2]};

  always_comb begin
    state_next = state_reg;
    load       = 1'b0;
    step       = 1'b0;
    finish     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          load       = 1'b1;
          state_next = CALC;
        end
      end
      CALC: begin
        step = 1'b1;
        if (cnt_reg == CNT_W'(K-1)) begin
          finish     = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        if (start) begin
          load       = 1'b1;
          state_next = CALC;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_reg       <= '0;
      acc_reg     <= '0;
      q_reg       <= '0;
      qm1_reg     <= 1'b0;
      cnt_reg     <= '0;
      product_reg <= '0;
    end else if (load) begin
      m_reg   <= ext_a;
      acc_reg <= '0;
      q_reg   <= ext_b;
      qm1_reg <= 1'b0;
      cnt_reg <= '0;
    end else if (step) begin
      acc_reg <= acc_next;
      q_reg   <= q_next;
      qm1_reg <= q_reg[1];
      cnt_reg <= cnt_reg + 1'b1;
      // Low 2*WIDTH bits of {ACC,Q} after the final shift hold the exact product.
      if (finish) begin
        product_reg <= {acc_next[WIDTH-3:0], q_next};
      end
    end
  end

  assign busy    = (state_reg == CALC);
  assign done    = (state_reg == DONE);
  assign product = product_reg;

endmodule

// File: tb/tb_booth_r4_mult.sv
// Directed and swept checks of booth_r4_mult at WIDTH=8 and WIDTH=16.
module tb_booth_r4_mult;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;

  logic        start8 = 1'b0, sm8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        busy8, done8;
  logic [15:0] prod8;

  logic        start16 = 1'b0, sm16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic        busy16, done16;
  logic [31:0] prod16;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  booth_r4_mult #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rstn(rstn), .start(start8), .signed_mode(sm8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .product(prod8)
  );

  booth_r4_mult #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rstn(rstn), .start(start16), .signed_mode(sm16), .a(a16), .b(b16),
    .busy(busy16), .done(done16), .product(prod16)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at posedge+1; returns in the cycle where done is high (or after a timeout).
  task automatic op8(input logic sm, input logic [7:0] ia, input logic [7:0] ib,
                     output logic [15:0] p, output int lat, output int busy_n);
    start8 = 1'b1; sm8 = sm; a8 = ia; b8 = ib;
    @(posedge clk); #1;
    start8 = 1'b0; sm8 = ~sm; a8 = 8'h5A; b8 = 8'hA5;
    lat = 0; busy_n = 0;
    while (!done8 && lat < 50) begin
      if (busy8) busy_n++;
      @(posedge clk); #1;
      lat++;
    end
    p = prod8;
  endtask

  task automatic op16(input logic sm, input logic [15:0] ia, input logic [15:0] ib,
                      output logic [31:0] p, output int lat);
    start16 = 1'b1; sm16 = sm; a16 = ia; b16 = ib;
    @(posedge clk); #1;
    start16 = 1'b0; sm16 = ~sm; a16 = 16'h1234; b16 = 16'h4321;
    lat = 0;
    while (!done16 && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    p = prod16;
  endtask

  initial begin
    logic [15:0] p8;
    logic [31:0] p16;
    logic [7:0]  ra8, rb8;
    logic [15:0] ra16, rb16;
    logic [15:0] e8;
    logic [31:0] e16;
    logic        rsm;
    int          lat, bn, gap;

    #2;
    check("rst_busy", busy8, 1'b0);
    check("rst_done", done8, 1'b0);
    check("rst_prod", prod8, 16'h0000);
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;

    // Signed -3*5 with latency and busy-length checks
    op8(1'b1, 8'hFD, 8'h05, p8, lat, bn);
    $display("t1 -3*5 signed: product=%h lat=%0d busy=%0d", p8, lat, bn);
    check("t1_prod", p8, 16'hFFF1);
    check("t1_lat", lat, 5);
    check("t1_busy", bn, 5);
    @(posedge clk); #1;
    check("t1_done_pulse", done8, 1'b0);
    check("t1_hold", prod8, 16'hFFF1);

    op8(1'b0, 8'hFF, 8'hFF, p8, lat, bn);
    $display("t2 FF*FF unsigned: product=%h", p8);
    check("t2_uns", p8, 16'hFE01);
    op8(1'b1, 8'hFF, 8'hFF, p8, lat, bn);
    $display("t2 FF*FF signed: product=%h", p8);
    check("t2_sgn", p8, 16'h0001);

    op8(1'b1, 8'h80, 8'h80, p8, lat, bn);
    $display("t3 80*80 signed: product=%h", p8);
    check("t3_minmin", p8, 16'h4000);
    op8(1'b1, 8'h80, 8'h7F, p8, lat, bn);
    $display("t3 80*7F signed: product=%h", p8);
    check("t3_minmax", p8, 16'hC080);
    op8(1'b0, 8'h00, 8'hB7, p8, lat, bn);
    $display("t3 00*B7 unsigned: product=%h", p8);
    check("t3_zero", p8, 16'h0000);
    @(posedge clk); #1;

    // start re-asserted during CALC must be ignored
    start8 = 1'b1; sm8 = 1'b0; a8 = 8'd3; b8 = 8'd4;
    @(posedge clk); #1;
    a8 = 8'd9; b8 = 8'd9;
    repeat (2) @(posedge clk);
    #1 start8 = 1'b0;
    lat = 2;
    while (!done8 && lat < 50) begin @(posedge clk); #1; lat++; end
    $display("t4 3*4 with start in CALC: product=%h lat=%0d", prod8, lat);
    check("t4_ignore", prod8, 16'h000C);
    check("t4_ignore_lat", lat, 5);
    @(posedge clk); #1;

    // start held through DONE: back-to-back, next done K+1 cycles later
    start8 = 1'b1; sm8 = 1'b0; a8 = 8'd2; b8 = 8'd3;
    @(posedge clk); #1;
    a8 = 8'd5; b8 = 8'd6;
    lat = 0;
    while (!done8 && lat < 50) begin @(posedge clk); #1; lat++; end
    $display("t4 back-to-back first: product=%h", prod8);
    check("t4_b2b_first", prod8, 16'h0006);
    @(posedge clk); #1;
    start8 = 1'b0;
    check("t4_no_bubble", busy8, 1'b1);
    gap = 1;
    while (!done8 && gap < 50) begin @(posedge clk); #1; gap++; end
    $display("t4 back-to-back second: product=%h gap=%0d", prod8, gap);
    check("t4_b2b_second", prod8, 16'h001E);
    check("t4_b2b_gap", gap, 6);
    @(posedge clk); #1;

    // Asynchronous reset during iteration 2 of 5
    start8 = 1'b1; sm8 = 1'b1; a8 = 8'h7F; b8 = 8'h7F;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (2) @(posedge clk);
    #2 rstn = 1'b0;
    #1;
    $display("t5 reset mid-CALC: busy=%b done=%b product=%h", busy8, done8, prod8);
    check("t5_busy", busy8, 1'b0);
    check("t5_done", done8, 1'b0);
    check("t5_prod", prod8, 16'h0000);
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;
    check("t5_idle_busy", busy8, 1'b0);
    check("t5_idle_done", done8, 1'b0);
    op8(1'b0, 8'd7, 8'd9, p8, lat, bn);
    $display("t5 7*9 after reset: product=%h", p8);
    check("t5_fresh", p8, 16'h003F);
    check("t5_fresh_lat", lat, 5);

    // WIDTH=16 directed corners
    op16(1'b1, 16'h8000, 16'h8000, p16, lat);
    $display("w16 8000*8000 signed: product=%h lat=%0d", p16, lat);
    check("w16_minmin", p16, 32'h4000_0000);
    check("w16_lat", lat, 9);
    op16(1'b0, 16'hFFFF, 16'hFFFF, p16, lat);
    $display("w16 FFFF*FFFF unsigned: product=%h", p16);
    check("w16_uns_max", p16, 32'hFFFE_0001);
    op16(1'b1, 16'hFFFD, 16'h0005, p16, lat);
    $display("w16 -3*5 signed: product=%h", p16);
    check("w16_neg", p16, 32'hFFFF_FFF1);

    // Random sweep against a*b of extended operands, modulo 2^(2*WIDTH)
    for (int i = 0; i < 1200; i++) begin
      ra8 = 8'($urandom); rb8 = 8'($urandom); rsm = 1'($urandom);
      e8 = (rsm ? {{8{ra8[7]}}, ra8} : {8'h00, ra8}) * (rsm ? {{8{rb8[7]}}, rb8} : {8'h00, rb8});
      op8(rsm, ra8, rb8, p8, lat, bn);
      $display("sweep8 %0d: sm=%b a=%h b=%h product=%h expected=%h", i, rsm, ra8, rb8, p8, e8);
      check("sweep8", p8, e8);
      check("sweep8_lat", lat, 5);
    end
    for (int i = 0; i < 1200; i++) begin
      ra16 = 16'($urandom); rb16 = 16'($urandom); rsm = 1'($urandom);
      e16 = (rsm ? {{16{ra16[15]}}, ra16} : {16'h0000, ra16}) *
            (rsm ? {{16{rb16[15]}}, rb16} : {16'h0000, rb16});
      op16(rsm, ra16, rb16, p16, lat);
      $display("sweep16 %0d: sm=%b a=%h b=%h product=%h expected=%h", i, rsm, ra16, rb16, p16, e16);
      check("sweep16", p16, e16);
      check("sweep16_lat", lat, 9);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
